// File: rtl/uart_rx_ctrl.sv
// UART receive controller: tracks bit/oversample position of an incoming frame and
// generates sampler, deserializer, parity-check and data-valid strobes plus error flags.
// Optional build macro UART_RX_START_GLITCH_CHK_EN: abort the frame when the start bit
// samples high at its bit end (false start caused by a line glitch).
module uart_rx_ctrl #(
  parameter int unsigned PRESCALE = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX_IN,
  input  logic       PAR_EN,
  input  logic       sampled_bit,
  input  logic       calculated_par_bit,
  output logic [3:0] bit_cnt,
  output logic [4:0] edge_cnt,
  output logic       dat_samp_en,
  output logic       deser_en,
  output logic       par_chk_en,
  output logic       data_valid_en,
  output logic       par_err,
  output logic       stp_err
);

  localparam logic [4:0] EdgeLast = 5'(PRESCALE - 1);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StStart  = 3'd1,
    StData   = 3'd2,
    StParity = 3'd3,
    StStop   = 3'd4
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] edge_q, edge_d;
  logic [3:0] bit_q, bit_d;
  logic       par_en_q, par_en_d;
  logic       par_err_q, par_err_d;
  logic       stp_err_q, stp_err_d;
  logic       bit_end;

  assign bit_end = (edge_q == EdgeLast);

  // State, counters and sticky error flags; reset forces everything idle and clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      edge_q    <= '0;
      bit_q     <= '0;
      par_en_q  <= 1'b0;
      par_err_q <= 1'b0;
      stp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      edge_q    <= edge_d;
      bit_q     <= bit_d;
      par_en_q  <= par_en_d;
      par_err_q <= par_err_d;
      stp_err_q <= stp_err_d;
    end
  end

  // Next-state, counter advance and strobe decode; every decision is taken at bit end.
  always_comb begin
    state_d       = state_q;
    edge_d        = edge_q;
    bit_d         = bit_q;
    par_en_d      = par_en_q;
    par_err_d     = par_err_q;
    stp_err_d     = stp_err_q;
    dat_samp_en   = 1'b0;
    deser_en      = 1'b0;
    par_chk_en    = 1'b0;
    data_valid_en = 1'b0;

    if (state_q != StIdle) begin
      dat_samp_en = 1'b1;
      if (bit_end) begin
        edge_d = '0;
        bit_d  = bit_q + 4'd1;
      end else begin
        edge_d = edge_q + 5'd1;
      end
    end

    unique case (state_q)
      StIdle: begin
        if (!RX_IN) begin
          state_d   = StStart;
          edge_d    = '0;
          bit_d     = '0;
          // Frame format is latched here so mid-frame PAR_EN changes are ignored.
          par_en_d  = PAR_EN;
          par_err_d = 1'b0;
          stp_err_d = 1'b0;
        end
      end
      StStart: begin
        if (bit_end) begin
`ifdef UART_RX_START_GLITCH_CHK_EN
          if (sampled_bit) begin
            state_d = StIdle;
            edge_d  = '0;
            bit_d   = '0;
          end else begin
            state_d = StData;
          end
`else
          state_d = StData;
`endif
        end
      end
      StData: begin
        if (bit_end) begin
          deser_en = 1'b1;
          if (bit_q == 4'd8) state_d = par_en_q ? StParity : StStop;
        end
      end
      StParity: begin
        par_chk_en = 1'b1;
        if (bit_end) begin
          par_err_d = (sampled_bit != calculated_par_bit);
          state_d   = StStop;
        end
      end
      StStop: begin
        if (bit_end) begin
          stp_err_d     = !sampled_bit;
          data_valid_en = sampled_bit && !(par_en_q && par_err_q);
          state_d       = StIdle;
          edge_d        = '0;
          bit_d         = '0;
        end
      end
      default: begin
        state_d = StIdle;
        edge_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  assign bit_cnt  = bit_q;
  assign edge_cnt = edge_q;
  assign par_err  = par_err_q;
  assign stp_err  = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Scoreboard bench for uart_rx_ctrl: the driver pushes the strobes each frame must
// produce (kind, bit index, cycle) and a monitor pops them as the DUT raises them.
module tb_uart_rx_ctrl;

  localparam int unsigned P = 8;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       RX_IN = 1'b1;
  logic       PAR_EN = 1'b0;
  logic       sampled_bit = 1'b1;
  logic       calculated_par_bit = 1'b0;
  logic [3:0] bit_cnt;
  logic [4:0] edge_cnt;
  logic       dat_samp_en, deser_en, par_chk_en, data_valid_en, par_err, stp_err;

  uart_rx_ctrl #(.PRESCALE(P)) dut (
    .CLK               (CLK),
    .RST               (RST),
    .RX_IN             (RX_IN),
    .PAR_EN            (PAR_EN),
    .sampled_bit       (sampled_bit),
    .calculated_par_bit(calculated_par_bit),
    .bit_cnt           (bit_cnt),
    .edge_cnt          (edge_cnt),
    .dat_samp_en       (dat_samp_en),
    .deser_en          (deser_en),
    .par_chk_en        (par_chk_en),
    .data_valid_en     (data_valid_en),
    .par_err           (par_err),
    .stp_err           (stp_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_valid;
    int unsigned bcnt;
    longint      cyc;
  } ev_t;

  ev_t    exp_q[$];
  longint cyc = 0;
  int     n_checks = 0;
  int     n_pass = 0;
  int     par_chk_cycles = 0;
  int     excl_viol = 0;

  always @(posedge CLK) cyc++;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic logic [14:0] all_outs();
    return {bit_cnt, edge_cnt, dat_samp_en, deser_en, par_chk_en, data_valid_en,
            par_err, stp_err};
  endfunction

  // Monitor: every deser_en / data_valid_en strobe must match the head of the queue.
  always @(negedge CLK) begin
    if (!RST) begin
      if (deser_en || data_valid_en) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_strobe", longint'(bit_cnt), -1);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("sb_kind_is_valid", longint'(data_valid_en), longint'(e.is_valid));
          check("sb_bit_cnt", longint'(bit_cnt), longint'(e.bcnt));
          check("sb_cycle", cyc, e.cyc);
        end
      end
      if (par_chk_en) par_chk_cycles++;
      if (int'(deser_en) + int'(data_valid_en) + int'(par_chk_en) > 1) excl_viol++;
    end
  end

  task automatic step();
    @(posedge CLK);
    #2;
  endtask

  task automatic idle(input int n);
    RX_IN = 1'b1;
    sampled_bit = 1'b1;
    repeat (n) step();
  endtask

  // Drives one frame at bit granularity, acting as an ideal sampler.
  // abort_bit != 0 pulses RST in the middle of that bit and abandons the frame.
  task automatic send_frame(input logic [7:0] data, input bit pe, input bit flip,
                            input bit stop, input int abort_bit);
    bit     bits[$];
    logic   calc;
    longint c1;
    int     pc0, stop_idx;
    calc = ^data;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(data[i]);
    if (pe) bits.push_back(calc ^ flip);
    bits.push_back(stop);
    stop_idx = bits.size() - 1;
    pc0 = par_chk_cycles;
    RX_IN = 1'b0;
    PAR_EN = pe;
    sampled_bit = 1'b0;
    calculated_par_bit = calc;
    step();
    c1 = cyc;
    for (int d = 1; d <= 8; d++)
      if (abort_bit == 0 || d < abort_bit)
        exp_q.push_back('{is_valid: 1'b0, bcnt: d, cyc: c1 + longint'(P * d + P - 1)});
    if (abort_bit == 0 && stop && !(pe && flip))
      exp_q.push_back('{is_valid: 1'b1, bcnt: stop_idx,
                        cyc: c1 + longint'(P * stop_idx + P - 1)});
    for (int b = 0; b <= stop_idx; b++) begin
      RX_IN = bits[b];
      sampled_bit = bits[b];
      if (b > 0) PAR_EN = 1'($urandom_range(0, 1));
      if (abort_bit != 0 && b == abort_bit) begin
        step();
        step();
        check("abort_bit_cnt_before_rst", longint'(bit_cnt), longint'(abort_bit));
        #1 RST = 1'b1;
        RX_IN = 1'b1;
        sampled_bit = 1'b1;
        #1 check("rst_async_outs_zero", longint'(all_outs()), 0);
        step();
        check("rst_held_outs_zero", longint'(all_outs()), 0);
        RST = 1'b0;
        return;
      end
      repeat (P) step();
    end
    check("frame_par_err", longint'(par_err), longint'(pe && flip));
    check("frame_stp_err", longint'(stp_err), longint'(!stop));
    check("frame_back_to_idle", longint'(dat_samp_en), 0);
    check("frame_par_chk_cycles", longint'(par_chk_cycles - pc0), pe ? longint'(P) : 0);
  endtask

  // Start bit low for only two cycles; the ideal sampler reports a high line.
  task automatic glitch();
    longint c1;
    RX_IN = 1'b0;
    PAR_EN = 1'b0;
    sampled_bit = 1'b1;
    calculated_par_bit = 1'b0;
    step();
    c1 = cyc;
`ifndef UART_RX_START_GLITCH_CHK_EN
    for (int d = 1; d <= 8; d++)
      exp_q.push_back('{is_valid: 1'b0, bcnt: d, cyc: c1 + longint'(P * d + P - 1)});
    exp_q.push_back('{is_valid: 1'b1, bcnt: 9, cyc: c1 + longint'(P * 9 + P - 1)});
`endif
    step();
    RX_IN = 1'b1;
    repeat (P - 1) step();
`ifdef UART_RX_START_GLITCH_CHK_EN
    check("glitch_idle_samp_en", longint'(dat_samp_en), 0);
    check("glitch_idle_counters", longint'({bit_cnt, edge_cnt}), 0);
`else
    check("glitch_data_bit_cnt", longint'(bit_cnt), 1);
`endif
    repeat (P * 9) step();
    check("glitch_end_idle", longint'(dat_samp_en), 0);
    check("glitch_stp_err", longint'(stp_err), 0);
  endtask

  initial begin
    #1 check("reset_outs_zero_t1", longint'(all_outs()), 0);
    repeat (3) @(posedge CLK);
    #2 check("reset_outs_zero_clocked", longint'(all_outs()), 0);
    RST = 1'b0;
    idle(3);
    check("idle_after_reset", longint'(all_outs()), 0);

    send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 0);   // plain frame, no parity
    idle(2);
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 0);   // good parity
    idle(2);
    send_frame(8'h5B, 1'b1, 1'b1, 1'b1, 0);   // bad parity
    idle(2);
    send_frame(8'hC3, 1'b0, 1'b0, 1'b0, 0);   // stop bit low
    idle(2);
    glitch();
    idle(2);
    send_frame(8'h96, 1'b0, 1'b0, 1'b1, 5);   // reset mid-frame
    idle(3);
    check("post_rst_idle", longint'(all_outs()), 0);
    send_frame(8'h69, 1'b0, 1'b0, 1'b1, 0);

    for (int i = 0; i < 20; i++) begin
      send_frame(8'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 4) != 0), 0);
      idle($urandom_range(0, 3));   // zero gives back-to-back frames
    end

    idle(5);
    check("sb_queue_drained", longint'(exp_q.size()), 0);
    check("strobe_exclusivity_violations", longint'(excl_viol), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL timeout: got no finish expected finish within 300000 ns");
    $fatal(1, "timeout");
  end

endmodule
